// File: rtl/router_pkg.sv
// Shared router constants and the header length decode used by every output FIFO.
package router_pkg;

    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 16;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;
    localparam int MAX_PKT_LEN  = 63;

    // Remaining-byte counter width: payload length (max 63) plus the parity byte.
    localparam int REM_W = 7;

    // Bytes still to come after a header: payload length plus one parity byte.
    function automatic logic [REM_W-1:0] hdr_rem_len(input logic [DATA_W-1:0] hdr_byte);
        logic [REM_W-1:0] len;
        len = {1'b0, hdr_byte[HDR_LEN_MSB:HDR_LEN_LSB]};
        return len + REM_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// FIFO storage array: one write port and one registered, enabled read port.
module router_fifo_mem #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::FIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W:0]   wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W:0]   rd_data_o
);

    logic [DATA_W:0] mem_q [DEPTH];
    logic [DATA_W:0] rd_data_q;

    // Write port and registered read port; the read register holds its value when idle.
    // NOTE: the array and read register are deliberately left without reset -- stale
    // entries are never visible because the pointers are reset, and a resettable array
    // would stop it mapping onto RAM.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/router_fifo_buf.sv
// Per-output-port packet FIFO: stores header/payload/parity bytes from the register stage,
// delivers them with one cycle of latency and flags the parity byte of each packet.
module router_fifo_buf #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::FIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              dout_valid,
    output logic              pkt_end,
    output logic              full,
    output logic              empty,
    output logic              wr_drop
);

    import router_pkg::*;

    localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      PTR_FULL = (AW+1)'(DEPTH);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [REM_W-1:0] rem_cnt_q, rem_cnt_d;
    logic             dout_valid_q;
    logic             rd_seen_q;
    logic             wr_drop_q;
    logic             flush;
    logic             wr_accept;
    logic             rd_accept;
    logic [DATA_W:0]  rd_entry;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full  = (wr_ptr_q - rd_ptr_q) == PTR_FULL;
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Either reset source flushes the FIFO and blocks any same-cycle transfer.
    assign flush     = reset || soft_reset;
    assign wr_accept = write_enb && !full && !flush;
    assign rd_accept = read_enb && !empty && !flush;

    router_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clock     (clock),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i ({lfd_state, data_in}),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_entry)
    );

    // Pointer advance and packet length tracking; length is updated from the byte being
    // presented this cycle, so pkt_end below sees the count before that byte is consumed.
    // NOTE: every variable gets its hold value first so no path through this block can
    // leave one unassigned and infer a latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rem_cnt_d = rem_cnt_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (dout_valid_q) begin
            if (rd_entry[DATA_W]) begin
                rem_cnt_d = hdr_rem_len(rd_entry[DATA_W-1:0]);
            end else if (rem_cnt_q != '0) begin
                rem_cnt_d = rem_cnt_q - REM_ONE;
            end
        end
    end

    // State registers with synchronous flush.
    // NOTE: non-blocking assignments here so every register samples pre-edge values,
    // independent of statement order.
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rem_cnt_q    <= '0;
            dout_valid_q <= 1'b0;
            rd_seen_q    <= 1'b0;
            wr_drop_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rem_cnt_q    <= rem_cnt_d;
            dout_valid_q <= rd_accept;
            rd_seen_q    <= rd_seen_q || rd_accept;
            wr_drop_q    <= write_enb && full;
        end
    end

    // data_out reads as zero until the first read after a flush, then holds the last byte.
    assign data_out   = rd_seen_q ? rd_entry[DATA_W-1:0] : '0;
    assign dout_valid = dout_valid_q;
    assign pkt_end    = dout_valid_q && !rd_entry[DATA_W] && (rem_cnt_q == REM_ONE);
    assign wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_router_fifo_buf.sv
// Self-checking bench for router_fifo_buf against a queue-based packet model.
module tb_router_fifo_buf;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       dout_valid;
    logic       pkt_end;
    logic       full;
    logic       empty;
    logic       wr_drop;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: stored entries plus what the outputs should show.
    logic [8:0] q[$];
    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_pend;
    logic       m_drop;
    int         m_rem;

    router_fifo_buf dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .dout_valid (dout_valid),
        .pkt_end    (pkt_end),
        .full       (full),
        .empty      (empty),
        .wr_drop    (wr_drop)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output 1 ns after the edge.
    task automatic cycle(input logic we, input logic lfd, input logic [7:0] din,
                         input logic re, input logic sr, input logic rst);
        logic       m_full;
        logic       m_empty;
        logic [8:0] e;
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        soft_reset = sr;
        reset      = rst;
        @(posedge clock);
        if (rst || sr) begin
            q.delete();
            m_dout  = 8'h00;
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_drop  = 1'b0;
            m_rem   = 0;
        end else begin
            m_full  = (q.size() == 16);
            m_empty = (q.size() == 0);
            m_drop  = we && m_full;
            m_valid = re && !m_empty;
            m_pend  = 1'b0;
            if (m_valid) begin
                e      = q.pop_front();
                m_dout = e[7:0];
                if (e[8]) begin
                    m_rem = int'(e[7:2]) + 1;
                end else if (m_rem != 0) begin
                    m_pend = (m_rem == 1);
                    m_rem  = m_rem - 1;
                end
            end
            if (we && !m_full) q.push_back({lfd, din});
        end
        #1;
        check("data_out",   32'(data_out),   32'(m_dout));
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("pkt_end",    32'(pkt_end),    32'(m_pend));
        check("wr_drop",    32'(wr_drop),    32'(m_drop));
        check("full",       32'(full),       32'(q.size() == 16));
        check("empty",      32'(empty),      32'(q.size() == 0));
    endtask

    task automatic wr(input logic lfd, input logic [7:0] din);
        cycle(1'b1, lfd, din, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int writes;
        int guard;
        logic do_w;
        logic do_r;

        m_dout = 8'h00; m_valid = 1'b0; m_pend = 1'b0; m_drop = 1'b0; m_rem = 0;

        // 1: reset overrides a simultaneous write; FIFO stays empty afterwards.
        cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1'b1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_data",  32'(data_out), 32'd0);
        idle();
        check("rst_no_write", 32'(empty), 32'd1);

        // 2: one packet, header length 3, pkt_end only with the parity byte.
        wr(1'b1, 8'h0D); wr(1'b0, 8'hA1); wr(1'b0, 8'hA2); wr(1'b0, 8'hA3); wr(1'b0, 8'h0E);
        for (int i = 0; i < 5; i++) rd();
        check("pkt_last_byte", 32'(data_out), 32'h0E);
        check("pkt_end_parity", 32'(pkt_end), 32'd1);
        idle();
        check("dout_hold", 32'(data_out), 32'h0E);
        rd();  // read while empty is ignored

        // 3: fill to 16, the 17th write is dropped, then drain in order.
        for (int i = 0; i < 17; i++) wr(1'b0, 8'(8'h30 + i));
        check("full_after_16", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) rd();
        check("drain_last", 32'(data_out), 32'h3F);
        check("drain_empty", 32'(empty), 32'd1);

        // 4: simultaneous read/write at full -- only the read happens.
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'hC0 + i));
        cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0);
        check("sim_full_out", 32'(data_out), 32'hC0);
        check("sim_full_clear", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) rd();

        // 5: soft reset mid-packet, then a fresh 1-byte packet completes normally.
        wr(1'b1, 8'h28);
        for (int i = 0; i < 11; i++) wr(1'b0, 8'(8'h90 + i));
        for (int i = 0; i < 4; i++) rd();
        cycle(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0);
        check("srst_empty", 32'(empty), 32'd1);
        check("srst_valid", 32'(dout_valid), 32'd0);
        wr(1'b1, 8'h04); wr(1'b0, 8'h5A); wr(1'b0, 8'h5E);
        rd(); rd(); rd();
        check("srst_pkt_end", 32'(pkt_end), 32'd1);

        // 6: 40 random bytes streamed with occupancy kept in 3..12.
        writes = 0;
        guard  = 0;
        while ((writes < 40 || q.size() != 0) && guard < 1000) begin
            guard++;
            do_w = (writes < 40) && ((q.size() < 3) || ($urandom_range(0, 1) == 1));
            do_r = (q.size() > 0) && (((q.size() > 12) || (writes >= 40)) ||
                   ((q.size() >= 3) && ($urandom_range(0, 1) == 1)));
            if (q.size() >= 12) do_w = 1'b0;
            if (do_w) writes++;
            cycle(do_w, 1'b0, 8'($urandom), do_r, 1'b0, 1'b0);
        end
        check("wrap_done", 32'(guard < 1000), 32'd1);

        // Random packets with headers, orphans, truncations and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                  8'($urandom_range(0, 15) << 2 | $urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0),
                  1'($urandom_range(0, 120) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
